// File: rtl/lsu_mem_port.sv
// Load/store port: decodes mem_store/mem_load, issues one word-wide req/ack access,
// steers store bytes onto lanes and extracts/extends load data.
module lsu_mem_port #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mem_store,
    input  logic [2:0]  mem_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        illegal,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    lane_reg;
    logic [1:0]    size_reg;     // 0 byte, 1 halfword, 2 word
    logic          sext_reg;
    logic          is_load_reg;

    logic          store_act, load_act, is_noop, is_illegal, is_misal, sext_d;
    logic [1:0]    size_d;
    logic [3:0]    be_d;
    logic [31:0]   wd_d;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [CW-1:0] cnt_next;

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign bus_req  = (state_reg == REQ);
    assign cnt_next = cnt_reg + CW'(1);

    always_comb begin
        store_act  = (mem_store != 2'b11);
        load_act   = (mem_load != 3'b111);
        is_noop    = !store_act && !load_act;
        // 101/110 are illegal on their own; any load code next to a store is illegal
        is_illegal = (mem_load == 3'b101) || (mem_load == 3'b110) || (store_act && load_act);
        size_d     = 2'd0;
        sext_d     = 1'b0;
        if (store_act) begin
            size_d = mem_store;
        end else begin
            case (mem_load)
                3'b000:  begin size_d = 2'd0; sext_d = 1'b1; end
                3'b001:  begin size_d = 2'd1; sext_d = 1'b1; end
                3'b010:  size_d = 2'd2;
                3'b011:  size_d = 2'd0;
                3'b100:  size_d = 2'd1;
                default: size_d = 2'd0;
            endcase
        end
        is_misal = ((size_d == 2'd1) && addr[0]) || ((size_d == 2'd2) && (addr[1:0] != 2'b00));
        case (size_d)
            2'd0:    begin be_d = 4'b0001 << addr[1:0];               wd_d = {4{wdata[7:0]}};  end
            2'd1:    begin be_d = addr[1] ? 4'b1100 : 4'b0011;       wd_d = {2{wdata[15:0]}}; end
            default: begin be_d = 4'b1111;                           wd_d = wdata;            end
        endcase
    end

    always_comb begin
        byte_sel = bus_rdata[8*lane_reg +: 8];
        half_sel = bus_rdata[16*lane_reg[1] +: 16];
        case (size_reg)
            2'd0:    load_val = {{24{sext_reg & byte_sel[7]}}, byte_sel};
            2'd1:    load_val = {{16{sext_reg & half_sel[15]}}, half_sel};
            default: load_val = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            lane_reg    <= 2'b00;
            size_reg    <= 2'd0;
            sext_reg    <= 1'b0;
            is_load_reg <= 1'b0;
            rdata       <= 32'h0;
            misalign    <= 1'b0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'h0;
            bus_wdata   <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !is_noop) begin
                        if (is_illegal) begin
                            illegal   <= 1'b1;
                            state_reg <= DONE;
                        end else if (is_misal) begin
                            misalign  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            lane_reg    <= addr[1:0];
                            size_reg    <= size_d;
                            sext_reg    <= sext_d;
                            is_load_reg <= !store_act;
                            bus_we      <= store_act;
                            bus_addr    <= {addr[31:2], 2'b00};
                            bus_be      <= be_d;
                            bus_wdata   <= wd_d;
                            cnt_reg     <= '0;
                            state_reg   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (is_load_reg) begin
                            rdata <= load_val;
                        end
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_next == TIMEOUT_LIMIT)) begin
                        bus_err   <= 1'b1;
                        rdata     <= 32'h0;
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                DONE: begin
                    misalign  <= 1'b0;
                    illegal   <= 1'b0;
                    bus_err   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store unit that consumes the decoder's mem_store/mem_load codes and executes one data-memory access per request over a word-wide req/ack bus. Write path: byte-lane steering and byte enables. Read path: lane extraction with sign/zero extension. Sits between execute (address from ALU, store data from rs2) and the data-memory bus, and stalls the pipeline via busy while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 16, number of REQ cycles without bus_ack before the access aborts with bus_err; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
mem_store  input  2  00 SB, 01 SH, 10 SW, 11 no store
mem_load  input  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 111 no load; other values illegal
addr  input  32  byte address
wdata  input  32  store data (rs2)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result
misalign  output  1  valid with done; access was misaligned
illegal  output  1  valid with done; illegal code combination
bus_err  output  1  valid with done; timeout
bus_req  output  1  memory request, held until ack
bus_we  output  1  1 for store
bus_addr  output  32  {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  memory accept / read-data valid
bus_rdata  input  32  read word, valid when bus_ack=1

Behaviour:
- States: IDLE, REQ, DONE. Reset (async, immediate) puts the FSM in IDLE. All outputs and internal registers are 0 at reset, including rdata and the timeout counter. Reset during REQ drops bus_req at once; no done is issued for the aborted access.
- IDLE, start=1, mem_store=11 and mem_load=111: no-op. Nothing is latched, the FSM stays in IDLE, done stays low.
- IDLE, start=1 with an illegal combination goes straight to DONE with illegal=1 and no bus access. Illegal means: both codes active, mem_store active alongside an illegal mem_load value, or mem_load in {101,110}.
- IDLE, start=1 with a misaligned access goes straight to DONE with misalign=1 and no bus access. Misaligned means: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=00.
- Any other IDLE start latches op, addr and wdata, then moves to REQ.
- REQ: bus_req=1. bus_addr, bus_we, bus_be and bus_wdata are driven from registers and stay stable until ack.
- Byte enables: SB/LB/LBU use be=0001<<addr[1:0]. SH/LH/LHU use be=addr[1]?1100:0011. SW/LW use be=1111.
- Write data: SB drives {4{wdata[7:0]}}, SH drives {2{wdata[15:0]}}, SW drives wdata.
- REQ with bus_ack=1: moves to DONE. On a load, rdata is captured in the same edge:
  - Byte lane is bus_rdata[8*addr[1:0]+:8]. Halfword lane is bus_rdata[16*addr[1]+:16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word.
- Stores leave rdata unchanged.
- Timeout: a counter increments on each REQ cycle without ack. When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, the FSM goes to DONE with bus_err=1. bus_req drops, rdata is forced to 0, and the counter clears.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. misalign, illegal and bus_err are meaningful only while done=1; they are 0 otherwise.
- start is ignored while busy=1. The earliest new accept is the cycle after DONE.
- Latency with start accepted at edge T: bus_req is high from T+1. Zero-wait ack gives done at T+2. Misaligned or illegal requests give done at T+1.
- rdata holds its value between loads. It is updated only on a load ack or cleared on timeout.

Test Plan:
- SB, addr=0x0000_0103, wdata=0x1234_56AB, immediate ack -> bus_addr=0x100, bus_be=1000, bus_wdata=0xABAB_ABAB, bus_we=1, done at T+2, rdata unchanged.
- LB addr=0x102 with bus_rdata=0x0080_0000 -> rdata=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080. LH addr=0x102, bus_rdata=0x8001_0000 -> 0xFFFF_8001.
- LW addr=0x200, ack after 3 wait cycles -> bus_req high for 4 cycles with stable addr/be=1111, rdata=bus_rdata, single done pulse, start during busy ignored.
- LH addr=0x101 -> no bus_req, done+misalign=1 at T+1. mem_store=10 with mem_load=010 -> done+illegal=1. Both codes none -> no done, busy stays 0.
- TIMEOUT_CYCLES=4, SW with no ack -> bus_req high 4 cycles, then done+bus_err=1, rdata=0, back to IDLE. A new request afterwards completes normally.
- rst_n asserted during the 2nd REQ cycle -> bus_req, busy and done go 0 asynchronously. After release, the FSM is in IDLE and the next load works.
